cic_dec_ctrl: RTL



---
 rtl/cic_dec_ctrl.sv | 138 +++++++++++++
 1 files changed

// File: rtl/cic_dec_ctrl.sv
// cic_dec_ctrl: sequencing controller for an N-stage CIC decimator.
// Gates samples into the integrators, counts modulo R, and times dec_en/out_valid.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   cfg_ratio  decimation ratio R (0 -> 1, >RMAX -> RMAX)
//   cfg_load   latch cfg_ratio (IDLE only)
//   start      IDLE -> ARM
//   stop       ARM/RUN -> DRAIN
//   val_in     input sample strobe
//   int_en     integrator stage 1 valid (val_in while RUN)
//   clr_dp     one-cycle datapath clear (ARM)
//   dec_en     downsample / comb stage 1 enable
//   out_valid  comb chain output valid
//   busy       controller not idle
//   drop_cnt   samples dropped outside RUN (only with CIC_DEC_CTRL_DROP_CNT_EN)
//
// Optional feature macro: CIC_DEC_CTRL_DROP_CNT_EN
module cic_dec_ctrl #(
    parameter int N    = 3,
    parameter int RMAX = 64,
    parameter int WR   = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [WR-1:0] cfg_ratio,
    input  logic          cfg_load,
    input  logic          start,
    input  logic          stop,
    input  logic          val_in,
    output logic          int_en,
    output logic          clr_dp,
    output logic          dec_en,
    output logic          out_valid,
`ifdef CIC_DEC_CTRL_DROP_CNT_EN
    output logic [15:0]   drop_cnt,
`endif
    output logic          busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARM,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t        r_state;
    logic [WR-1:0] r_ratio;
    logic [WR-1:0] r_phase;
    logic [N-1:0]  r_itag;
    logic [N-1:0]  r_ctag;

    logic [WR-1:0] w_ratio_ld;
    logic          w_tag;
    logic          w_tags_empty;

    always_comb begin
        w_ratio_ld = cfg_ratio;
        if (cfg_ratio == '0) begin
            w_ratio_ld = WR'(1);
        end else if (cfg_ratio > WR'(RMAX)) begin
            w_ratio_ld = WR'(RMAX);
        end
    end

    assign int_en       = val_in && (r_state == S_RUN);
    // Tag marks the R-th accepted sample; it rides alongside the data.
    assign w_tag        = int_en && (r_phase == r_ratio - WR'(1));
    assign w_tags_empty = (r_itag == '0) && (r_ctag == '0);

    assign clr_dp    = (r_state == S_ARM);
    assign busy      = (r_state != S_IDLE);
    assign dec_en    = r_itag[N-1];
    assign out_valid = r_ctag[N-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_ratio <= WR'(1);
            r_phase <= '0;
            r_itag  <= '0;
            r_ctag  <= '0;
        end else begin
            // Tag pipes mirror the integrator and comb latencies.
            r_itag <= (r_itag << 1) | N'(w_tag);
            r_ctag <= (r_ctag << 1) | N'(r_itag[N-1]);

            unique case (r_state)
                S_IDLE: begin
                    if (cfg_load) begin
                        r_ratio <= w_ratio_ld;
                    end
                    if (start) begin
                        r_state <= S_ARM;
                    end
                end
                S_ARM: begin
                    r_phase <= '0;
                    r_state <= stop ? S_DRAIN : S_RUN;
                end
                S_RUN: begin
                    if (int_en) begin
                        r_phase <= w_tag ? '0 : r_phase + WR'(1);
                    end
                    if (stop) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (w_tags_empty) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef CIC_DEC_CTRL_DROP_CNT_EN
    logic [15:0] r_drop;

    assign drop_cnt = r_drop;

    // Cleared on entry to ARM so the count reads 0 throughout ARM.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop <= '0;
        end else if ((r_state == S_IDLE && start) || r_state == S_ARM) begin
            r_drop <= '0;
        end else if (val_in && r_state != S_RUN && r_drop != 16'hFFFF) begin
            r_drop <= r_drop + 16'd1;
        end
    end
`endif

endmodule
